// File: rtl/core_pkg.sv
// Shared core types: hazard-controller FSM states and register-index constants.
package core_pkg;
  localparam int REG_IDX_W  = 5;
  localparam int WAIT_CNT_W = 16;
  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, EX redirects and
// data-memory waits, plus saturating perf counters and a sticky timeout flag.
module pipeline_hazard_ctrl import core_pkg::*; #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1_addr,
  input  logic [REG_IDX_W-1:0] id_rs2_addr,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_wb_reg_file,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic [1:0]           ctrl_state,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events,
  output logic                 mem_timeout
);
  localparam logic [WAIT_CNT_W-1:0] TO_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  // Assert immediately, release two clocks after rst drops.
  logic [1:0] rst_sync;
  logic       rst_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  ctrl_state_t           state, state_nxt;
  logic                  memw, lu, rs1_hit, rs2_hit;
  logic                  stall_all, lu_stall, flush_ifid, flush_idex;
  logic                  flush_inc, wait_inc, wait_clr;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  assign memw    = mem_req & ~mem_ready;
  assign rs1_hit = id_uses_rs1 && (id_rs1_addr == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2_addr == ex_rd);
  assign lu      = ex_mem_read && ex_wb_reg_file && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

  always_comb begin
    stall_all  = 1'b0;
    lu_stall   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    flush_inc  = 1'b0;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    state_nxt  = state;
    if (!rst_i) begin
      case (state)
        MEM_WAIT: begin
          // EX is frozen here, so redirect/load-use wait until RUN.
          if (memw) begin stall_all = 1'b1; wait_inc = 1'b1; end
          else state_nxt = RUN;
        end
        REDIRECT: begin
          if (memw) stall_all = 1'b1;
          else begin flush_ifid = 1'b1; state_nxt = RUN; end
        end
        default: begin
          state_nxt = RUN;
          if (memw) begin
            stall_all = 1'b1;
            wait_clr  = 1'b1;
            state_nxt = MEM_WAIT;
          end else if (ex_redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flush_inc  = 1'b1;
            state_nxt  = REDIRECT;
          end else if (lu) begin
            lu_stall   = 1'b1;
            flush_idex = 1'b1;
          end
        end
      endcase
    end
  end

  assign pc_stall     = stall_all | lu_stall;
  assign if_id_stall  = stall_all | lu_stall;
  assign if_id_flush  = flush_ifid;
  assign id_ex_stall  = stall_all;
  assign id_ex_flush  = flush_idex;
  assign ex_mem_stall = stall_all;
  assign ctrl_state   = state;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state       <= RUN;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wait_inc && wait_cnt >= TO_LAST) mem_timeout <= 1'b1;
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst_i), .inc(pc_stall), .clr(1'b0), .cnt(stall_cycles));

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst_i), .inc(flush_inc), .clr(1'b0), .cnt(flush_events));

  hazard_sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk(clk), .rst(rst_i), .inc(wait_inc), .clr(wait_clr), .cnt(wait_cnt));
endmodule
